// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared definitions for the up/down counter controller:
//                FSM state encoding, count limit, mode encoding and the
//                decimal wrap-around step function.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // FSM state encoding (2-bit, explicit width)
    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    // Largest value shown on the 4-digit display
    localparam logic [13:0] MAX_COUNT = 14'd9999;

    // Direction switch encoding
    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    // One count step in the selected direction, wrapping inside 0..MAX_COUNT
    function automatic logic [13:0] next_count(input logic [13:0] count,
                                               input logic        mode);
        logic [13:0] result;
        result = count;
        case (mode)
            MODE_UP:   result = (count == MAX_COUNT) ? 14'd0 : count + 14'd1;
            MODE_DOWN: result = (count == 14'd0) ? MAX_COUNT : count - 14'd1;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/updown_counter_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Clock divider producing a one-cycle tick every DIV enabled
//                cycles. The divider holds while disabled so that a paused
//                counter resumes with the same tick phase; clr zeroes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
    import counter_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // DIV is at least 2, so the counter is always at least one bit wide
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_div_cnt;

    // Divider: clear wins, otherwise count 0..DIV-1 only while enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (clr) begin
            r_div_cnt <= '0;
        end else if (en) begin
            if (r_div_cnt == c_last) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    // Terminal count while enabled; en is a state decode, so this is register-only
    assign tick = en && (r_div_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/updown_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter_ctrl
//  Description : Run/stop/clear controller for a 0..9999 decimal up/down
//                counter feeding the FND display path. Three-state FSM
//                (STOP / RUN / one-cycle CLEAR), tick divider sub-module,
//                registered count, registered mode LED and optional blinking
//                decimal point on digit 1.
//  Options     : COUNTER_DOT_BLINK_EN - when defined, the digit-1 dot toggles
//                every BLINK_TICKS ticks in RUN; otherwise all dots stay off.
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_ctrl
    import counter_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int TICK_HZ     = 10,
    parameter int BLINK_TICKS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_run_stop,
    input  logic        btn_clear,
    input  logic        sw_mode,
    output logic [13:0] fndData,
    output logic [3:0]  fndDot,
    output logic        run_led,
    output logic        mode_led
);

    // Divider terminal count; must be at least 2
    localparam int DIV = CLK_FREQ / TICK_HZ;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        w_en;
    logic        w_clr;
    logic        w_tick;
    logic [13:0] r_count;
    logic        r_mode;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: clear beats run/stop in STOP, clear is ignored in RUN
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_STOP: begin
                if (btn_clear) begin
                    w_state_next = ST_CLEAR;
                end else if (btn_run_stop) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (btn_run_stop) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_CLEAR: begin
                w_state_next = ST_STOP;
            end
            default: begin
                w_state_next = ST_STOP;
            end
        endcase
    end

    // Output decode: all derived from the state register only
    always_comb begin
        w_en    = (r_state == ST_RUN);
        w_clr   = (r_state == ST_CLEAR);
        run_led = (r_state == ST_RUN);
    end

    // ------------------------------------------------------------------------
    // Tick divider
    // ------------------------------------------------------------------------
    tick_gen #(
        .DIV   (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (w_en),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    // ------------------------------------------------------------------------
    // Count datapath
    // ------------------------------------------------------------------------

    // Count register: zeroed in CLEAR, stepped on each tick in the sampled direction.
    // A run/stop pulse coinciding with a tick still lets the tick apply, since
    // the state is RUN during that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 14'd0;
        end else if (w_clr) begin
            r_count <= 14'd0;
        end else if (w_tick) begin
            r_count <= next_count(r_count, sw_mode);
        end
    end

    assign fndData = r_count;

    // Mode LED: registered copy of the direction switch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode <= 1'b0;
        end else begin
            r_mode <= sw_mode;
        end
    end

    assign mode_led = r_mode;

    // ------------------------------------------------------------------------
    // Decimal-point blink
    // ------------------------------------------------------------------------
`ifdef COUNTER_DOT_BLINK_EN
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BLINK_W-1:0] c_blink_last = BLINK_W'(BLINK_TICKS - 1);

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_dot_on;

    // Blink counter and dot state: advance only on ticks, hold in STOP, off on CLEAR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_dot_on    <= 1'b0;
        end else if (w_clr) begin
            r_blink_cnt <= '0;
            r_dot_on    <= 1'b0;
        end else if (w_tick) begin
            if (r_blink_cnt == c_blink_last) begin
                r_blink_cnt <= '0;
                r_dot_on    <= ~r_dot_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Active-low dots: only digit 1 blinks
    assign fndDot = {1'b1, 1'b1, ~r_dot_on, 1'b1};
`else
    localparam int c_unused_blink_ticks = BLINK_TICKS;

    // All dots permanently off
    assign fndDot = 4'b1111;
`endif

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_updown_counter_ctrl
//  Description : Self-checking bench for updown_counter_ctrl with DIV = 10 and
//                BLINK_TICKS = 2. Expected count updates (value and edge
//                number) are queued when stimulus is driven and consumed by a
//                monitor whenever fndData changes. Dot checks follow
//                COUNTER_DOT_BLINK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter_ctrl;

    localparam int c_div = 10;

`ifdef COUNTER_DOT_BLINK_EN
    localparam logic [3:0] c_dot_lit = 4'b1101;
`else
    localparam logic [3:0] c_dot_lit = 4'b1111;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_run_stop = 1'b0;
    logic        btn_clear = 1'b0;
    logic        sw_mode = 1'b0;
    logic [13:0] fndData;
    logic [3:0]  fndDot;
    logic        run_led;
    logic        mode_led;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [13:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    bit          mon_en = 1'b1;
    logic [13:0] last_data = 14'd0;

    updown_counter_ctrl #(
        .CLK_FREQ    (100),
        .TICK_HZ     (10),
        .BLINK_TICKS (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_run_stop (btn_run_stop),
        .btn_clear    (btn_clear),
        .sw_mode      (sw_mode),
        .fndData      (fndData),
        .fndDot       (fndDot),
        .run_led      (run_led),
        .mode_led     (mode_led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every change of fndData must match the queue head
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en && (fndData !== last_data)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: fndData=%0d at edge %0d, no update expected", fndData, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.data !== fndData || e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL sb_update: got %0d at edge %0d, expected %0d at edge %0d",
                             fndData, cyc, e.data, e.cyc);
                end
            end
            last_data = fndData;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [13:0] d, input int c);
        exp_q.push_back('{d, c});
    endtask

    // All tasks start and end at a falling edge
    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic pulse_now(input logic run, input logic clr, output int e);
        @(negedge clk);
        e = cyc + 1;
        btn_run_stop = run;
        btn_clear    = clr;
        @(negedge clk);
        btn_run_stop = 1'b0;
        btn_clear    = 1'b0;
    endtask

    task automatic pulse_at(input logic run, input logic clr, input int target);
        while (cyc + 1 < target) @(negedge clk);
        if (cyc + 1 != target) begin
            n_err++;
            $display("FAIL schedule: pulse wanted at edge %0d, now at %0d", target, cyc + 1);
        end
        btn_run_stop = run;
        btn_clear    = clr;
        @(negedge clk);
        btn_run_stop = 1'b0;
        btn_clear    = 1'b0;
    endtask

    task automatic do_clear(input logic [13:0] cur);
        int e;
        pulse_now(1'b0, 1'b1, e);
        if (cur != 14'd0) push(14'd0, e + 1);
        wait_to(e + 2);
    endtask

    task automatic test_reset;
        sw_mode = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (fndData !== 14'd0) begin n_err++; $display("FAIL reset_data: got %0d want 0", fndData); end
        n_cmp++; if (fndDot !== 4'b1111) begin n_err++; $display("FAIL reset_dot: got %b want 1111", fndDot); end
        n_cmp++; if (run_led !== 1'b0) begin n_err++; $display("FAIL reset_run_led: got %b want 0", run_led); end
        n_cmp++; if (mode_led !== 1'b0) begin n_err++; $display("FAIL reset_mode_led: got %b want 0", mode_led); end
        reset   = 1'b0;
        sw_mode = 1'b0;
        @(negedge clk);
        n_cmp++; if (run_led !== 1'b0) begin n_err++; $display("FAIL post_reset_run_led: got %b want 0", run_led); end
    endtask

    task automatic test_up_count;
        int n;
        int e;
        sw_mode = 1'b0;
        pulse_now(1'b1, 1'b0, n);
        push(14'd1, n + 10);
        push(14'd2, n + 20);
        push(14'd3, n + 30);
        wait_to(n + 35);
        n_cmp++; if (fndData !== 14'd3) begin n_err++; $display("FAIL up_data: got %0d want 3", fndData); end
        n_cmp++; if (run_led !== 1'b1) begin n_err++; $display("FAIL up_run_led: got %b want 1", run_led); end
        n_cmp++; if (mode_led !== 1'b0) begin n_err++; $display("FAIL up_mode_led: got %b want 0", mode_led); end
        pulse_at(1'b1, 1'b0, n + 36);
        n_cmp++; if (run_led !== 1'b0) begin n_err++; $display("FAIL stop_run_led: got %b want 0", run_led); end
        pulse_now(1'b0, 1'b1, e);
        push(14'd0, e + 1);
        n_cmp++; if (run_led !== 1'b0) begin n_err++; $display("FAIL clear_state_run_led: got %b want 0", run_led); end
        wait_to(e + 2);
        n_cmp++; if (fndData !== 14'd0) begin n_err++; $display("FAIL clear_data: got %0d want 0", fndData); end
    endtask

    task automatic test_pause_resume;
        int n;
        int r;
        pulse_now(1'b1, 1'b0, n);
        push(14'd1, n + 10);
        pulse_at(1'b1, 1'b0, n + 15);
        wait_to(n + 66);
        n_cmp++; if (fndData !== 14'd1) begin n_err++; $display("FAIL pause_hold: got %0d want 1", fndData); end
        n_cmp++; if (run_led !== 1'b0) begin n_err++; $display("FAIL pause_run_led: got %b want 0", run_led); end
        pulse_now(1'b1, 1'b0, r);
        push(14'd2, r + 5);
        wait_to(r + 4);
        n_cmp++; if (fndData !== 14'd1) begin n_err++; $display("FAIL resume_early: got %0d want 1", fndData); end
        pulse_at(1'b1, 1'b0, r + 8);
        do_clear(14'd2);
    endtask

    task automatic test_wrap;
        int n;
        sw_mode = 1'b1;
        pulse_now(1'b1, 1'b0, n);
        push(14'd9999, n + 10);
        push(14'd9998, n + 20);
        wait_to(n + 24);
        n_cmp++; if (mode_led !== 1'b1) begin n_err++; $display("FAIL wrap_mode_led: got %b want 1", mode_led); end
        sw_mode = 1'b0;
        push(14'd9999, n + 30);
        push(14'd0,    n + 40);
        wait_to(n + 44);
        sw_mode = 1'b1;
        push(14'd9999, n + 50);
        pulse_at(1'b1, 1'b0, n + 53);
        n_cmp++; if (fndData !== 14'd9999) begin n_err++; $display("FAIL wrap_final: got %0d want 9999", fndData); end
        sw_mode = 1'b0;
        do_clear(14'd9999);
    endtask

    task automatic test_simultaneous;
        int n;
        int e;
        pulse_now(1'b1, 1'b0, n);
        for (int k = 1; k <= 7; k++) push(14'(k), n + 10 * k);
        pulse_at(1'b1, 1'b0, n + 75);
        n_cmp++; if (fndData !== 14'd7) begin n_err++; $display("FAIL simul_pre: got %0d want 7", fndData); end
        pulse_now(1'b1, 1'b1, e);
        push(14'd0, e + 1);
        n_cmp++; if (run_led !== 1'b0) begin n_err++; $display("FAIL simul_clear_run_led: got %b want 0", run_led); end
        wait_to(e + 1);
        n_cmp++; if (fndData !== 14'd0) begin n_err++; $display("FAIL simul_data: got %0d want 0", fndData); end
        wait_to(e + 15);
        n_cmp++; if (run_led !== 1'b0) begin n_err++; $display("FAIL simul_stays_stop: got %b want 0", run_led); end
        // clear pulse in RUN must be ignored
        pulse_now(1'b1, 1'b0, n);
        push(14'd1, n + 10);
        push(14'd2, n + 20);
        pulse_at(1'b0, 1'b1, n + 13);
        n_cmp++; if (run_led !== 1'b1) begin n_err++; $display("FAIL run_clear_run_led: got %b want 1", run_led); end
        n_cmp++; if (fndData !== 14'd1) begin n_err++; $display("FAIL run_clear_data: got %0d want 1", fndData); end
        pulse_at(1'b1, 1'b0, n + 25);
        do_clear(14'd2);
    endtask

    task automatic test_back_to_back;
        int n;
        int r;
        // stop pulse coinciding with a tick: tick applies and divider restarts
        pulse_now(1'b1, 1'b0, n);
        push(14'd1, n + 10);
        pulse_at(1'b1, 1'b0, n + 10);
        n_cmp++; if (run_led !== 1'b0) begin n_err++; $display("FAIL tick_stop_run_led: got %b want 0", run_led); end
        n_cmp++; if (fndData !== 14'd1) begin n_err++; $display("FAIL tick_stop_data: got %0d want 1", fndData); end
        pulse_now(1'b1, 1'b0, r);
        push(14'd2, r + 10);
        pulse_at(1'b1, 1'b0, r + 12);
        do_clear(14'd2);
    endtask

    task automatic test_dot;
        int n;
        logic [3:0] want [6];
        want = '{4'b1111, c_dot_lit, c_dot_lit, 4'b1111, 4'b1111, c_dot_lit};
        pulse_now(1'b1, 1'b0, n);
        for (int k = 1; k <= 6; k++) push(14'(k), n + 10 * k);
        for (int k = 0; k < 6; k++) begin
            wait_to(n + 15 + 10 * k);
            n_cmp++;
            if (fndDot !== want[k]) begin
                n_err++;
                $display("FAIL dot_run_%0d: got %b want %b", k, fndDot, want[k]);
            end
        end
        pulse_at(1'b1, 1'b0, n + 67);
        wait_to(n + 87);
        n_cmp++; if (fndDot !== c_dot_lit) begin n_err++; $display("FAIL dot_hold_stop: got %b want %b", fndDot, c_dot_lit); end
        do_clear(14'd6);
        n_cmp++; if (fndDot !== 4'b1111) begin n_err++; $display("FAIL dot_clear: got %b want 1111", fndDot); end
    endtask

    task automatic test_async_reset;
        int n;
        int r;
        sw_mode = 1'b1;
        pulse_now(1'b1, 1'b0, n);
        push(14'd9999, n + 10);
        wait_to(n + 15);
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        n_cmp++; if (fndData !== 14'd0) begin n_err++; $display("FAIL areset_data: got %0d want 0", fndData); end
        n_cmp++; if (fndDot !== 4'b1111) begin n_err++; $display("FAIL areset_dot: got %b want 1111", fndDot); end
        n_cmp++; if (run_led !== 1'b0) begin n_err++; $display("FAIL areset_run_led: got %b want 0", run_led); end
        n_cmp++; if (mode_led !== 1'b0) begin n_err++; $display("FAIL areset_mode_led: got %b want 0", mode_led); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (fndData !== 14'd0) begin n_err++; $display("FAIL areset_held_data: got %0d want 0", fndData); end
        n_cmp++; if (mode_led !== 1'b0) begin n_err++; $display("FAIL areset_held_mode: got %b want 0", mode_led); end
        reset   = 1'b0;
        sw_mode = 1'b0;
        @(negedge clk);
        n_cmp++; if (run_led !== 1'b0) begin n_err++; $display("FAIL areset_after_run_led: got %b want 0", run_led); end
        last_data = fndData;
        mon_en    = 1'b1;
        // divider must have restarted from zero
        pulse_now(1'b1, 1'b0, r);
        push(14'd1, r + 10);
        pulse_at(1'b1, 1'b0, r + 12);
        do_clear(14'd1);
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_pause_resume();
        test_wrap();
        test_simultaneous();
        test_back_to_back();
        test_dot();
        test_async_reset();
        wait_to(cyc + 3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d expected updates never seen, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/updown_counter_ctrl.md
# updown_counter_ctrl

Run/stop/clear controller for a 4-digit decimal up/down counter that drives the FND display path. It sequences a 0..9999 counter at a fixed tick rate and direction chosen by a switch. It presents the count as `fndData[13:0]` and the decimal-point pattern as `fndDot[3:0]`, which feed the FND controller directly. It sits between the debounced button/switch inputs and the display controller.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `TICK_HZ`, default 10: count rate in Hz. Divider terminal `DIV = CLK_FREQ/TICK_HZ`, which must be ≥ 2.
- `BLINK_TICKS`, default 5: number of ticks per dot toggle.
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: asynchronous, active-high reset.
- `btn_run_stop` in 1: one-cycle pulse, already debounced and edge-detected.
- `btn_clear` in 1: one-cycle pulse, already debounced and edge-detected.
- `sw_mode` in 1: 0 = count up, 1 = count down. Level input.
- `fndData` out 14: current count, 0..9999.
- `fndDot` out 4: active-low dot enables, bit i maps to digit i.
- `run_led` out 1: high while in RUN.
- `mode_led` out 1: registered copy of `sw_mode`.

## Operation
- FSM states:
  - STOP (reset state).
  - RUN.
  - CLEAR (transient, one cycle).
- Transitions from STOP:
  - `btn_clear` → CLEAR.
  - else `btn_run_stop` → RUN.
  - If both pulses arrive in the same cycle, clear wins.
- Transitions from RUN:
  - `btn_run_stop` → STOP.
  - `btn_clear` is ignored.
- CLEAR lasts one cycle, then goes unconditionally to STOP. In that cycle: count ← 0, divider ← 0, blink counter ← 0, dot state ← off.
- Divider `div_cnt` runs 0..DIV-1 in RUN only.
  - It holds its value in STOP, so pause/resume preserves the tick phase.
  - A tick is `div_cnt == DIV-1` while in RUN. On a tick, `div_cnt` ← 0.
- On a tick, the count updates according to `sw_mode` sampled on that cycle:
  - up: 9999 → 0 wraps, otherwise +1.
  - down: 0 → 9999 wraps, otherwise −1.
  - Count arithmetic is 14-bit unsigned. Values above 9999 are never produced.
- A `btn_run_stop` pulse that coincides with a tick takes the state to STOP, and the tick still applies: the count updates and `div_cnt` ← 0.
- `mode_led` is registered from `sw_mode` every cycle.
- Reset mid-operation returns everything asynchronously to reset values. No tick or count update survives.

## Timing
- Reset values:
  - state STOP
  - `fndData` = 0
  - `fndDot` = 4'b1111
  - `run_led` = 0
  - `mode_led` = 0
  - `div_cnt` = 0
  - blink counter = 0
- All outputs are registered or are decodes of registers only. There is no combinational path from any input to any output.
- Button pulse at edge N → state change visible after edge N; `run_led` follows in the same cycle as the state.
- From a cleared divider, entering RUN at edge N gives the first count update at edge N+DIV. After that, updates come every DIV cycles.
- Clear pulse while in STOP at edge N → CLEAR during the cycle after edge N; `fndData` = 0 after edge N+1; STOP after edge N+1.
- A `sw_mode` change takes effect on the next tick. There is no glitch in `fndData`.

## Configuration
- `COUNTER_DOT_BLINK_EN`:
  - Defined:
    - In RUN, a 1-bit dot state toggles every `BLINK_TICKS` ticks, counted by a blink counter 0..BLINK_TICKS-1.
    - `fndDot` = {1, 1, ~dot_on, 1}: the digit-1 dot (bit 1) blinks.
    - In STOP, the dot state holds its current value.
    - CLEAR and reset force the dot off.
  - Undefined: `fndDot` is constant 4'b1111, and the blink counter and dot register are not built.

## Structure
- Shared package `counter_pkg`:
  - state encoding localparams ST_STOP = 2'd0, ST_RUN = 2'd1, ST_CLEAR = 2'd2
  - MAX_COUNT = 9999
  - MODE_UP = 1'b0, MODE_DOWN = 1'b1
- One sub-module, `tick_gen`:
  - Parameter `DIV`.
  - Inputs: `clk`, `reset`, `en` (state == RUN), `clr` (state == CLEAR).
  - Output: one-cycle `tick` (`div_cnt == DIV-1` while `en`).
- The FSM, count register, and blink logic live in the top.

## Test plan
Bench parameters: `CLK_FREQ` = 100, `TICK_HZ` = 10 (DIV = 10), `BLINK_TICKS` = 2, with `COUNTER_DOT_BLINK_EN` defined.
- Up count: after reset, pulse run, `sw_mode` = 0, wait 35 cycles → `fndData` = 3, `run_led` = 1.
- Wrap: preload to 9998 by counting, up mode, 2 ticks → 9999 then 0. Down mode from 0, 1 tick → 9999.
- Pause/resume phase: run 15 cycles (count 1, `div_cnt` 5), stop 50 cycles with no change, run again → count 2 exactly 5 cycles after resume.
- Simultaneous: in STOP with count 7, pulse `btn_run_stop` and `btn_clear` in the same cycle → CLEAR, then STOP, `fndData` = 0, `run_led` stays 0. Clear pulse while in RUN → ignored, count continues.
- Dot: in RUN, `fndDot` alternates 4'b1111 / 4'b1101 every 2 ticks (20 cycles). Without the macro, `fndDot` stays 4'b1111 throughout.
- Async reset asserted mid-RUN, between clock edges → all outputs at reset values immediately. No update occurs on the next edge while reset is held.
